// File: rtl/instruction_fetch_controller_pkg.sv
// instruction_fetch_controller_pkg: shared FSM state encoding and IR half-select constants.
package instruction_fetch_controller_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH_LO = 2'd1,
        FETCH_HI = 2'd2,
        DONE     = 2'd3
    } state_e;

    localparam logic IR_LOW  = 1'b0;
    localparam logic IR_HIGH = 1'b1;

endpackage

// File: rtl/instruction_fetch_controller_program_counter.sv
// program_counter: ADDR_W-bit PC with sync reset, load and modulo increment-by-1.
//   clk_i  : clock
//   rst_i  : synchronous active-high reset, clears PC
//   load_i : load pc from d_i (priority over inc_i)
//   d_i    : load value
//   inc_i  : increment pc by one, wrapping at 2^ADDR_W
//   pc_o   : current pc
module program_counter #(
    parameter int ADDR_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] d_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q, pc_d;

    always_comb pc_d = load_i ? d_i : inc_i ? pc_q + ADDR_W'(1) : pc_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) pc_q <= '0;
        else       pc_q <= pc_d;
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch_controller.sv
// instruction_fetch_controller: fetches a 16-bit instruction as two byte reads into the IR.
//   Clock, Reset       : clock, synchronous active-high reset
//   Start, PCLoad, PCIn: fetch request / PC load (only honoured in IDLE, load wins)
//   MemRead, MemAddress: byte read request at the current PC, held until MemValid
//   MemData, MemValid  : read data and its qualifier
//   IRData, IRWrite, IRLH: instruction register byte, write strobe, half select
//   PCOut, Busy, Done  : current PC, non-IDLE flag, one-cycle completion pulse
module instruction_fetch_controller
    import instruction_fetch_controller_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic              PCLoad,
    input  logic [ADDR_W-1:0] PCIn,
    output logic              MemRead,
    output logic [ADDR_W-1:0] MemAddress,
    input  logic [7:0]        MemData,
    input  logic              MemValid,
    output logic [7:0]        IRData,
    output logic              IRWrite,
    output logic              IRLH,
    output logic [ADDR_W-1:0] PCOut,
    output logic              Busy,
    output logic              Done
);

    state_e            state_q;
    logic [ADDR_W-1:0] pc;
    logic              fetching;
    logic              accept;

    // Outputs are masked by Reset so nothing leaks out during the reset cycle,
    // including an in-flight fetch being abandoned.
    assign fetching = (state_q == FETCH_LO || state_q == FETCH_HI) && !Reset;
    assign accept   = fetching && MemValid;

    always_ff @(posedge Clock) begin
        if (Reset) state_q <= IDLE;
        else begin
            case (state_q)
                IDLE:     if (Start && !PCLoad) state_q <= FETCH_LO;
                FETCH_LO: if (MemValid) state_q <= FETCH_HI;
                FETCH_HI: if (MemValid) state_q <= DONE;
                default:  state_q <= IDLE;
            endcase
        end
    end

    program_counter #(.ADDR_W(ADDR_W)) u_pc (
        .clk_i  (Clock),
        .rst_i  (Reset),
        .load_i (state_q == IDLE && PCLoad),
        .d_i    (PCIn),
        .inc_i  (accept),
        .pc_o   (pc)
    );

    assign MemRead    = fetching;
    assign MemAddress = pc;
    assign IRData     = MemData;
    assign IRWrite    = accept;
    assign IRLH       = (state_q == FETCH_HI) ? IR_HIGH : IR_LOW;
    assign PCOut      = Reset ? '0 : pc;
    assign Busy       = state_q != IDLE && !Reset;
    assign Done       = state_q == DONE && !Reset;

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// tb_instruction_fetch_controller: scoreboard bench for the instruction fetch controller.
module tb_instruction_fetch_controller;

    logic        Clock = 1'b0;
    logic        Reset, Start, PCLoad, MemValid;
    logic [15:0] PCIn;
    logic [7:0]  MemData;
    logic        MemRead, IRWrite, IRLH, Busy, Done;
    logic [15:0] MemAddress, PCOut;
    logic [7:0]  IRData;

    typedef struct {
        logic [15:0] addr;
        logic        lh;
        logic [7:0]  data;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [7:0]  mem [logic [15:0]];
    logic [15:0] ir;
    int          errors = 0;
    int          checks = 0;
    int          wr_cnt = 0;
    int          stall_cfg = 0;
    int          stall_cnt = 0;

    instruction_fetch_controller #(.ADDR_W(16)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Start      (Start),
        .PCLoad     (PCLoad),
        .PCIn       (PCIn),
        .MemRead    (MemRead),
        .MemAddress (MemAddress),
        .MemData    (MemData),
        .MemValid   (MemValid),
        .IRData     (IRData),
        .IRWrite    (IRWrite),
        .IRLH       (IRLH),
        .PCOut      (PCOut),
        .Busy       (Busy),
        .Done       (Done)
    );

    always #5 Clock = ~Clock;

    // Memory: answers after stall_cfg wait cycles per byte request.
    always @(posedge Clock) begin
        #1;
        if (MemRead === 1'b1) begin
            if (stall_cnt < stall_cfg) begin
                MemValid = 1'b0;
                stall_cnt++;
            end else begin
                MemValid  = 1'b1;
                MemData   = mem.exists(MemAddress) ? mem[MemAddress] : 8'h00;
                stall_cnt = 0;
            end
        end else begin
            MemValid  = 1'b0;
            stall_cnt = 0;
        end
    end

    // Monitor: address stability and IR writes against the scoreboard.
    always @(negedge Clock) begin
        if (MemRead === 1'b1 && sb.size() > 0) begin
            checks++;
            if (MemAddress !== sb[0].addr) begin
                errors++;
                $display("FAIL mem_address got=%h want=%h", MemAddress, sb[0].addr);
            end
        end
        if (IRWrite === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_irwrite got=1 want=0 at %0t", $time);
            end else begin
                e = sb.pop_front();
                if ({IRLH, IRData} !== {e.lh, e.data}) begin
                    errors++;
                    $display("FAIL ir_byte got=%b/%h want=%b/%h", IRLH, IRData, e.lh, e.data);
                end
                if (IRLH) ir[15:8] = IRData;
                else      ir[7:0]  = IRData;
                wr_cnt++;
            end
        end
    end

    task automatic load_pc(input logic [15:0] v);
        @(negedge Clock);
        PCLoad = 1'b1;
        PCIn   = v;
        @(negedge Clock);
        PCLoad = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge Clock);
        Start = 1'b1;
        @(posedge Clock);
        #1 Start = 1'b0;
    endtask

    // Counts negedges after the Start edge until Done; -1 on timeout.
    task automatic wait_done(output int n);
        n = 1;
        @(negedge Clock);
        while (Done !== 1'b1 && n < 60) begin
            @(negedge Clock);
            n++;
        end
        if (Done !== 1'b1) n = -1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; Start = 1'b0; PCLoad = 1'b0; PCIn = '0;
        MemValid = 1'b0; MemData = '0;
        @(negedge Clock);
        @(negedge Clock);
        checks++;
        if ({MemRead, IRWrite, Done, Busy, PCOut} !== 20'h0) begin
            errors++;
            $display("FAIL reset_outputs got=%b%b%b%b/%h want=0000/0000", MemRead, IRWrite, Done, Busy, PCOut);
        end
        Reset = 1'b0;
        @(negedge Clock);
        checks++;
        if ({MemRead, IRWrite, Done, Busy, PCOut} !== 20'h0) begin
            errors++;
            $display("FAIL post_reset_outputs got=%b%b%b%b/%h want=0000/0000", MemRead, IRWrite, Done, Busy, PCOut);
        end
    endtask

    task automatic test_load_priority();
        logic rd_seen;
        rd_seen = 1'b0;
        @(negedge Clock);
        PCLoad = 1'b1; PCIn = 16'h0040; Start = 1'b1;
        @(negedge Clock);
        PCLoad = 1'b0; Start = 1'b0;
        checks++;
        if (PCOut !== 16'h0040 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL load_priority got pc=%h busy=%b want pc=0040 busy=0", PCOut, Busy);
        end
        for (int i = 0; i < 4; i++) begin
            rd_seen |= (MemRead !== 1'b0) || (Busy !== 1'b0);
            @(negedge Clock);
        end
        checks++;
        if (rd_seen) begin
            errors++;
            $display("FAIL load_no_fetch got memread/busy=1 want=0");
        end
    endtask

    task automatic test_fetch();
        int n;
        sb.push_back('{16'h0040, 1'b0, 8'h15});
        sb.push_back('{16'h0041, 1'b1, 8'h23});
        wr_cnt = 0; stall_cfg = 0; ir = '0;
        pulse_start();
        wait_done(n);
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL fetch_latency got=%0d want=3", n);
        end
        checks++;
        if (ir !== 16'h2315 || wr_cnt !== 2 || PCOut !== 16'h0042) begin
            errors++;
            $display("FAIL fetch_result got ir=%h wr=%0d pc=%h want ir=2315 wr=2 pc=0042", ir, wr_cnt, PCOut);
        end
        @(negedge Clock);
        checks++;
        if (Done !== 1'b0 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse got done=%b busy=%b want done=0 busy=0", Done, Busy);
        end
    endtask

    task automatic test_wait_states();
        int n;
        load_pc(16'h0040);
        sb.push_back('{16'h0040, 1'b0, 8'h15});
        sb.push_back('{16'h0041, 1'b1, 8'h23});
        wr_cnt = 0; stall_cfg = 3; ir = '0;
        pulse_start();
        wait_done(n);
        stall_cfg = 0;
        checks++;
        if (n !== 9) begin
            errors++;
            $display("FAIL wait_latency got=%0d want=9", n);
        end
        checks++;
        if (ir !== 16'h2315 || wr_cnt !== 2 || PCOut !== 16'h0042) begin
            errors++;
            $display("FAIL wait_result got ir=%h wr=%0d pc=%h want ir=2315 wr=2 pc=0042", ir, wr_cnt, PCOut);
        end
    endtask

    task automatic test_wrap();
        int n;
        load_pc(16'hFFFF);
        sb.push_back('{16'hFFFF, 1'b0, 8'hAB});
        sb.push_back('{16'h0000, 1'b1, 8'hCD});
        wr_cnt = 0; ir = '0;
        pulse_start();
        wait_done(n);
        checks++;
        if (n !== 3 || ir !== 16'hCDAB || PCOut !== 16'h0001) begin
            errors++;
            $display("FAIL wrap got n=%0d ir=%h pc=%h want n=3 ir=cdab pc=0001", n, ir, PCOut);
        end
    endtask

    task automatic test_reset_mid_fetch();
        int  t;
        logic bad;
        load_pc(16'h0040);
        sb.push_back('{16'h0040, 1'b0, 8'h15});
        sb.push_back('{16'h0041, 1'b1, 8'h23});
        wr_cnt = 0; stall_cfg = 3;
        pulse_start();
        t = 0;
        while (wr_cnt < 1 && t < 30) begin
            @(negedge Clock);
            t++;
        end
        checks++;
        if (wr_cnt !== 1) begin
            errors++;
            $display("FAIL mid_low_byte got=%0d want=1", wr_cnt);
        end
        @(negedge Clock);
        sb.delete();
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        stall_cfg = 0;
        checks++;
        if (Busy !== 1'b0 || PCOut !== 16'h0000 || MemRead !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got busy=%b pc=%h rd=%b want busy=0 pc=0000 rd=0", Busy, PCOut, MemRead);
        end
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bad |= (Done !== 1'b0) || (IRWrite !== 1'b0);
            @(negedge Clock);
        end
        checks++;
        if (bad || wr_cnt !== 1) begin
            errors++;
            $display("FAIL mid_reset_quiet got done/irwrite seen=%b wr=%0d want 0/1", bad, wr_cnt);
        end
    endtask

    task automatic test_ignore_during_fetch();
        int n;
        load_pc(16'h0100);
        sb.push_back('{16'h0100, 1'b0, 8'h15});
        sb.push_back('{16'h0101, 1'b1, 8'h23});
        wr_cnt = 0; stall_cfg = 3; ir = '0;
        pulse_start();
        @(negedge Clock);
        Start = 1'b1; PCLoad = 1'b1; PCIn = 16'h1234;
        @(negedge Clock);
        @(negedge Clock);
        Start = 1'b0; PCLoad = 1'b0;
        wait_done(n);
        stall_cfg = 0;
        checks++;
        if (n < 0 || ir !== 16'h2315 || PCOut !== 16'h0102) begin
            errors++;
            $display("FAIL ignore_result got n=%0d ir=%h pc=%h want ir=2315 pc=0102", n, ir, PCOut);
        end
        repeat (3) @(negedge Clock);
        checks++;
        if (Busy !== 1'b0 || PCOut !== 16'h0102 || wr_cnt !== 2) begin
            errors++;
            $display("FAIL ignore_not_queued got busy=%b pc=%h wr=%0d want 0/0102/2", Busy, PCOut, wr_cnt);
        end
    endtask

    initial begin
        mem[16'h0040] = 8'h15; mem[16'h0041] = 8'h23;
        mem[16'hFFFF] = 8'hAB; mem[16'h0000] = 8'hCD;
        mem[16'h0100] = 8'h15; mem[16'h0101] = 8'h23;
        test_reset();
        test_load_priority();
        test_fetch();
        test_wait_states();
        test_wrap();
        test_reset_mid_fetch();
        test_ignore_during_fetch();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_controller.md
INSTRUCTION_FETCH_CONTROLLER -- requirements
Module: instruction_fetch_controller

Interface
REQ-001 Parameter: ADDR_W, 16, width of PC and memory address.
REQ-002 Port: Clock  in  1  sole clock; all state updates on rising edge.
REQ-003 Port: Reset  in  1  synchronous, active-high reset.
REQ-004 Port: Start  in  1  request one 16-bit instruction fetch; sampled only in IDLE.
REQ-005 Port: PCLoad  in  1  load PC from PCIn; sampled only in IDLE.
REQ-006 Port: PCIn  in  ADDR_W  new PC value.
REQ-007 Port: MemRead  out  1  byte read request, held until MemValid.
REQ-008 Port: MemAddress  out  ADDR_W  byte address of request, equal to current PC.
REQ-009 Port: MemData  in  8  read data, qualified by MemValid.
REQ-010 Port: MemValid  in  1  read data valid; ignored unless MemRead is high.
REQ-011 Port: IRData  out  8  byte to instruction register I input, equal to MemData.
REQ-012 Port: IRWrite  out  1  instruction register Write strobe.
REQ-013 Port: IRLH  out  1  instruction register half select: 0 = low byte [7:0], 1 = high byte [15:8].
REQ-014 Port: PCOut  out  ADDR_W  current PC.
REQ-015 Port: Busy  out  1  high in any state other than IDLE.
REQ-016 Port: Done  out  1  one-cycle pulse after both halves are written.

Function
REQ-017 The FSM SHALL have four states: IDLE, FETCH_LO, FETCH_HI, DONE.
REQ-018 IDLE with PCLoad=1 SHALL load PC<=PCIn, remain in IDLE, and ignore Start that cycle (PCLoad has priority).
REQ-019 IDLE with Start=1 and PCLoad=0 SHALL transition to FETCH_LO on the next edge.
REQ-020 In FETCH_LO and FETCH_HI, MemRead SHALL be 1 and MemAddress SHALL equal PC; in all other states MemRead SHALL be 0.
REQ-021 In FETCH_LO or FETCH_HI with MemValid=0, the FSM SHALL hold its state and PC, with IRWrite=0; no timeout exists.
REQ-022 In FETCH_LO with MemValid=1, the block SHALL drive IRWrite=1, IRLH=0, IRData=MemData combinationally in that cycle, set PC<=PC+1, and go to FETCH_HI.
REQ-023 In FETCH_HI with MemValid=1, the block SHALL drive IRWrite=1, IRLH=1, IRData=MemData, set PC<=PC+1, and go to DONE.
REQ-024 DONE SHALL assert Done=1 for exactly one cycle and return unconditionally to IDLE.
REQ-025 PC arithmetic SHALL be modulo 2^ADDR_W; the high byte of a fetch at 0xFFFF SHALL come from address 0x0000.
REQ-026 PCLoad and Start outside IDLE SHALL be ignored and not queued.
REQ-027 IRWrite SHALL be 0 in every cycle where it is not explicitly asserted above; IRLH and IRData are don't-care when IRWrite=0.
REQ-028 Minimum fetch latency with MemValid always high SHALL be: Start at edge N; low byte written at edge N+1; high byte written at edge N+2; Done high during cycle N+2..N+3.

Reset
REQ-029 On Reset=1 at a rising edge, the block SHALL set the state to IDLE and PC to 0; Reset takes priority over all other inputs.
REQ-030 While in reset and on the first cycle after reset, the outputs SHALL be: MemRead=0, IRWrite=0, Done=0, Busy=0, PCOut=0.
REQ-031 Reset during FETCH_LO or FETCH_HI SHALL abandon the fetch with no further IRWrite; a partially written IR is not restored.

Structure
REQ-032 The state encoding (2-bit) SHALL be placed in the shared project package, alongside the IR half-select constants IR_LOW=0 and IR_HIGH=1.
REQ-033 The PC SHALL be a sub-module program_counter providing load, increment-by-1 and reset, with ADDR_W as a parameter; the FSM and output decode remain in the top module.

Verification
REQ-034 Reset, PCLoad=1 with PCIn=0x0040, Start=1 in the same cycle -> PCOut=0x0040, state remains IDLE, MemRead never asserted.
REQ-035 PC=0x0040, Start, memory returns 0x15 then 0x23 with MemValid always high -> IRWrite/IRLH=0 with 0x15, then IRLH=1 with 0x23; IR=0x2315; Done pulse; PCOut=0x0042.
REQ-036 Same fetch with MemValid held low for 3 cycles before each byte -> MemRead and MemAddress held stable, no IRWrite while waiting, IR=0x2315, total of 9 cycles from Start to Done.
REQ-037 PC=0xFFFF, Start -> addresses 0xFFFF then 0x0000; PCOut=0x0001 after Done.
REQ-038 Reset asserted in FETCH_HI -> next cycle IDLE, PCOut=0, no IRWrite, no Done.
REQ-039 Start and PCLoad=1 with PCIn=0x1234 during FETCH_LO -> both ignored; fetch completes from the original PC; PCOut=original+2.
